intr_gen_mc: RTL and testbench
==============================

# intr_gen_mc

Synthesizable, parametrised multi-channel random interrupt generator for the Kudu simulation testbench. It drives NUM_IRQ interrupt request lines into the core under test. Each request follows a randomised quiet interval, is held until the core acknowledges it, and can optionally be re-raised back-to-back. Randomness comes from an internal seeded LFSR instead of simulator calls, so sequences are reproducible across simulators and usable on FPGA.

## Interface
- NUM_IRQ, default 3: number of interrupt channels (1..16).
- MIN_WAIT, default 10: quiet-interval granularity, in clk cycles (≥1).
- CNT_W, default 20: wait-counter width; must hold (2^15)*MIN_WAIT.
- LFSR_SEED, default 32'hACE1_2468: LFSR reset value; 0 is replaced by 1.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-high (asserted when rst_n=1).
- intr_intvl  in  4  interval exponent; 0 disables new interrupts.
- intr_en  in  1  global generation enable.
- irq_mask  in  NUM_IRQ  per-channel enable; only set bits may be raised.
- multi_mode  in  1  0 = one channel per event; 1 = random subset.
- b2b_en  in  1  allows back-to-back re-raise without a quiet interval.
- intr_ack  in  NUM_IRQ  per-channel acknowledge, level-sampled.
- irq_o  out  NUM_IRQ  interrupt request lines, registered.
- busy  out  1  high when the state is not IDLE.
- irq_count  out  32  count of raise events; wraps at 2^32.

## Operation
- LFSR: 32-bit Galois, taps 0x80200003. It advances on every clk edge while not in reset. "lfsr" below means the value before the deciding edge.
- States: IDLE, WAIT, ASSERT.
- IDLE → WAIT when intr_en=1, intr_intvl≠0 and irq_mask≠0.
  - Load cnt = ((lfsr mod 2^intr_intvl) + 1) * MIN_WAIT.
  - Otherwise remain in IDLE.
- WAIT: cnt decrements every cycle. Changes to intr_intvl, irq_mask or multi_mode during WAIT are ignored until the decision point.
- WAIT decision at cnt==1:
  - If intr_en=1 and irq_mask≠0: irq_o ← pattern, irq_count += 1, go to ASSERT.
  - Else go to IDLE with irq_o unchanged at 0.
- Pattern, multi_mode=0: start index i = lfsr[7:0] mod NUM_IRQ. Select the first set irq_mask bit at i, i+1, …, wrapping at NUM_IRQ. Exactly one bit is set.
- Pattern, multi_mode=1: p = lfsr[NUM_IRQ-1:0] & irq_mask. If p=0, use the lowest set bit of irq_mask instead.
- ASSERT: each irq_o bit clears at the edge where its intr_ack bit is sampled high.
  - intr_ack bits for channels not currently asserted are ignored.
  - intr_en=0 does not retract pending requests. Only ack clears them.
- ASSERT, last remaining bit cleared:
  - If b2b_en=1, intr_en=1, lfsr[31]=0 and irq_mask≠0: load a new pattern at the same edge (irq_o never drops to 0), irq_count += 1, stay in ASSERT.
  - Else irq_o → 0 and go to IDLE.
- Simultaneous ack of all asserted bits is treated as the last clear; the rule above applies.

## Timing
- Reset values: irq_o=0, busy=0, irq_count=0, state IDLE, cnt=0, lfsr=LFSR_SEED.
- Reset asserted mid-operation: all state returns immediately (asynchronously) to the reset values.
- Launch latency: the IDLE launch edge is E0. irq_o goes high at edge E0+N, where N is the loaded cnt. busy is high from E0+1.
- Ack latency: an intr_ack bit sampled high at edge E clears the irq_o bit at E. It is visible low in the cycle after E.
- Minimum spacing (non-b2b): after irq_o reaches 0, at least 1 IDLE cycle + MIN_WAIT cycles pass before the next raise.
- Request stability: irq_o bits never change in ASSERT except on ack or a b2b reload.

## Test plan
- Single channel, basic launch: irq_mask=3'b010, intr_intvl=1, multi_mode=0, b2b_en=0. Required: irq_o=3'b010 at 10 or 20 cycles after launch; ack 1 cycle clears it; busy falls; irq_count=1.
- Spacing: same setup, ack held high continuously, run 200 raises. Required: every raise-to-raise gap ≥ MIN_WAIT+2 and ≤ 2*MIN_WAIT+3; the cnt values matching the LFSR model reproduce exactly.
- Multi mode with partial ack: irq_mask=3'b111, multi_mode=1. Ack one asserted bit only. Required: only that bit drops; the others hold; the state returns to IDLE only after the final ack.
- Back-to-back: b2b_en=1, ack each bit on assertion. Required: irq_o has no zero cycle on reloads where lfsr[31]=0; irq_count increments per reload; irq_o returns to 0 otherwise.
- Enable and disable: drop intr_en during WAIT. Required: no raise, return to IDLE. Drop intr_en during ASSERT. Required: irq_o held until acked, then IDLE with no reload. intr_intvl=0 or irq_mask=0: busy stays 0.
- Reset mid-ASSERT: assert rst_n=1 while irq_o≠0. Required: irq_o=0 and irq_count=0 immediately. After release, the sequence is identical to a fresh run from LFSR_SEED.

Source files
------------

// File: rtl/intr_gen_mc.sv
// Multi-channel random interrupt generator: LFSR-timed quiet intervals, requests held
// until acknowledged, optional back-to-back re-raise.
module intr_gen_mc #(
  parameter int          NUM_IRQ   = 3,
  parameter int          MIN_WAIT  = 10,
  parameter int          CNT_W     = 20,
  parameter logic [31:0] LFSR_SEED = 32'hACE1_2468
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         intr_intvl,
  input  logic               intr_en,
  input  logic [NUM_IRQ-1:0] irq_mask,
  input  logic               multi_mode,
  input  logic               b2b_en,
  input  logic [NUM_IRQ-1:0] intr_ack,
  output logic [NUM_IRQ-1:0] irq_o,
  output logic               busy,
  output logic [31:0]        irq_count
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ASSERT = 2'd2
  } state_t;

  localparam logic [31:0] TAPS = 32'h8020_0003;
  localparam logic [31:0] SEED = (LFSR_SEED == 32'd0) ? 32'd1 : LFSR_SEED;

  state_t             state_r, state_nxt_s;
  logic [CNT_W-1:0]   cnt_r, cnt_nxt_s, cnt_load_s;
  logic [NUM_IRQ-1:0] irq_r, irq_nxt_s, pattern_s, remaining_s;
  logic [31:0]        count_r, count_nxt_s, lfsr_r, span_s, prod_s;
  logic               busy_r, mask_any_s, reload_ok_s;

  function automatic logic [31:0] lfsr_step(input logic [31:0] l);
    return {1'b0, l[31:1]} ^ (l[0] ? TAPS : 32'd0);
  endfunction

  function automatic logic [NUM_IRQ-1:0] pick_pattern(input logic [31:0] l,
                                                      input logic [NUM_IRQ-1:0] m,
                                                      input logic multi);
    logic [NUM_IRQ-1:0] one_hot, subset, lowest;
    logic               found, hit;
    int                 start;
    start   = int'(l[7:0]) % NUM_IRQ;
    one_hot = '0;
    found   = 1'b0;
    // First pass scans from the start index upward, second pass covers the wrap.
    for (int i = 0; i < NUM_IRQ; i++) begin
      hit        = !found && m[i] && (i >= start);
      one_hot[i] = hit;
      found      = found | hit;
    end
    for (int i = 0; i < NUM_IRQ; i++) begin
      hit        = !found && m[i];
      one_hot[i] = one_hot[i] | hit;
      found      = found | hit;
    end
    subset = l[NUM_IRQ-1:0] & m;
    lowest = m & (~m + NUM_IRQ'(1));
    return multi ? ((subset != '0) ? subset : lowest) : one_hot;
  endfunction

  assign mask_any_s  = |irq_mask;
  assign span_s      = (32'd1 << intr_intvl) - 32'd1;
  assign prod_s      = ((lfsr_r & span_s) + 32'd1) * 32'(MIN_WAIT);
  assign cnt_load_s  = prod_s[CNT_W-1:0];
  assign pattern_s   = pick_pattern(lfsr_r, irq_mask, multi_mode);
  assign remaining_s = irq_r & ~intr_ack;
  assign reload_ok_s = b2b_en && intr_en && !lfsr_r[31] && mask_any_s;

  // Next-state, counter, request and event-count logic
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    irq_nxt_s   = irq_r;
    count_nxt_s = count_r;
    case (state_r)
      ST_IDLE: begin
        if (intr_en && (intr_intvl != 4'd0) && mask_any_s) begin
          cnt_nxt_s   = cnt_load_s;
          state_nxt_s = ST_WAIT;
        end else begin
          cnt_nxt_s   = cnt_r;
        end
      end
      ST_WAIT: begin
        if (cnt_r <= CNT_W'(1)) begin
          cnt_nxt_s = '0;
          if (intr_en && mask_any_s) begin
            irq_nxt_s   = pattern_s;
            count_nxt_s = count_r + 32'd1;
            state_nxt_s = ST_ASSERT;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end else begin
          cnt_nxt_s = cnt_r - CNT_W'(1);
        end
      end
      ST_ASSERT: begin
        if (remaining_s != '0) begin
          irq_nxt_s = remaining_s;
        end else if (reload_ok_s) begin
          irq_nxt_s   = pattern_s;
          count_nxt_s = count_r + 32'd1;
        end else begin
          irq_nxt_s   = '0;
          state_nxt_s = ST_IDLE;
        end
      end
      default: begin
        irq_nxt_s   = '0;
        cnt_nxt_s   = '0;
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State registers; rst_n is an active-high asynchronous reset here
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= '0;
      irq_r   <= '0;
      count_r <= 32'd0;
      busy_r  <= 1'b0;
      lfsr_r  <= SEED;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      irq_r   <= irq_nxt_s;
      count_r <= count_nxt_s;
      busy_r  <= (state_nxt_s != ST_IDLE);
      lfsr_r  <= lfsr_step(lfsr_r);
    end
  end

  assign irq_o     = irq_r;
  assign busy      = busy_r;
  assign irq_count = count_r;

endmodule

// File: tb/tb_intr_gen_mc.sv
// Directed self-checking bench for intr_gen_mc with a reference LFSR for the random
// quiet intervals and channel patterns.
module tb_intr_gen_mc;

  localparam int          NI    = 3;
  localparam logic [31:0] SEED  = 32'hACE1_2468;
  localparam int          BOUND = 2000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [3:0]  intr_intvl = 4'd0;
  logic        intr_en = 1'b0;
  logic [2:0]  irq_mask = 3'd0;
  logic        multi_mode = 1'b0;
  logic        b2b_en = 1'b0;
  logic [2:0]  intr_ack = 3'd0;
  logic [2:0]  irq_o;
  logic        busy;
  logic [31:0] irq_count;

  int          n_checks = 0;
  int          n_errors = 0;
  int          exp_cnt  = 0;
  int          seq_buf[4];
  int          seq0[4];
  logic [31:0] m_lfsr, m_prev;

  intr_gen_mc #(.NUM_IRQ(NI), .MIN_WAIT(10), .CNT_W(20), .LFSR_SEED(SEED)) dut (
    .clk(clk), .rst_n(rst_n), .intr_intvl(intr_intvl), .intr_en(intr_en),
    .irq_mask(irq_mask), .multi_mode(multi_mode), .b2b_en(b2b_en),
    .intr_ack(intr_ack), .irq_o(irq_o), .busy(busy), .irq_count(irq_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] step(input logic [31:0] l);
    return (l >> 1) ^ ({32{l[0]}} & 32'h8020_0003);
  endfunction

  function automatic logic [2:0] pat0(input logic [31:0] l, input logic [2:0] m);
    int s, idx;
    logic [2:0] r;
    r = 3'd0;
    s = int'(l[7:0]) % NI;
    for (int k = NI - 1; k >= 0; k--) begin
      idx = (s + k) % NI;
      if (m[idx]) r = 3'd1 << idx;
    end
    return r;
  endfunction

  function automatic logic [2:0] pat1(input logic [31:0] l, input logic [2:0] m);
    logic [2:0] p;
    p = l[2:0] & m;
    if (p == 3'd0)
      for (int i = NI - 1; i >= 0; i--) if (m[i]) p = 3'd1 << i;
    return p;
  endfunction

  // Reference LFSR: m_prev is the value the DUT used at the most recent edge
  always @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      m_lfsr <= SEED;
      m_prev <= SEED;
    end else begin
      m_prev <= m_lfsr;
      m_lfsr <= step(m_lfsr);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_irq(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (irq_o == 3'd0 && n < BOUND);
    if (irq_o == 3'd0) check("irq_timeout", 32'(irq_o != 3'd0), 32'd1);
  endtask

  task automatic go_idle();
    @(negedge clk);
    intr_en = 1'b0; b2b_en = 1'b0; intr_ack = 3'b111;
    repeat (40) @(posedge clk);
    #1;
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_irq", 32'(irq_o), 32'd0);
    @(negedge clk);
    intr_ack = 3'd0;
  endtask

  task automatic fresh_seq();
    int n;
    logic [31:0] l;
    @(negedge clk);
    intr_intvl = 4'd1; irq_mask = 3'b010; multi_mode = 1'b0; b2b_en = 1'b0;
    intr_ack = 3'b010; intr_en = 1'b1; rst_n = 1'b0;
    exp_cnt = 0;
    wait_irq(n);
    seq_buf[0] = n;
    check("seq_first", n, 32'd11);
    check("seq_pat", 32'(irq_o), 32'b010);
    exp_cnt++;
    for (int i = 1; i < 4; i++) begin
      l = step(m_lfsr);
      wait_irq(n);
      seq_buf[i] = n;
      check("seq_gap", n, l[0] ? 32'd22 : 32'd12);
      exp_cnt++;
    end
  endtask

  initial begin
    int n, reloads, drops, any;
    logic [31:0] l, l0;
    logic [2:0]  exp, low, rest;
    logic        done;

    repeat (3) @(posedge clk);
    #1;
    check("rst_irq", 32'(irq_o), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_count", irq_count, 32'd0);

    fresh_seq();
    seq0 = seq_buf;
    check("seq_count", irq_count, 32'(exp_cnt));
    go_idle();

    // basic single-channel launch and one-cycle ack
    @(negedge clk);
    intr_intvl = 4'd1; irq_mask = 3'b010; multi_mode = 1'b0; b2b_en = 1'b0; intr_ack = 3'd0;
    l0 = m_lfsr; intr_en = 1'b1;
    @(posedge clk); #1;
    check("basic_busy", 32'(busy), 32'd1);
    wait_irq(n);
    check("basic_lat", n, l0[0] ? 32'd20 : 32'd10);
    check("basic_irq", 32'(irq_o), 32'b010);
    exp_cnt++;
    check("basic_count", irq_count, 32'(exp_cnt));
    @(negedge clk);
    intr_ack = 3'b010; intr_en = 1'b0;
    @(posedge clk); #1;
    check("basic_ack_irq", 32'(irq_o), 32'd0);
    check("basic_ack_busy", 32'(busy), 32'd0);
    @(negedge clk);
    intr_ack = 3'd0;

    // spacing with ack held high
    @(negedge clk);
    intr_ack = 3'b010; l = m_lfsr; intr_en = 1'b1;
    wait_irq(n);
    check("gap_first", n, l[0] ? 32'd21 : 32'd11);
    exp_cnt++;
    for (int i = 0; i < 200; i++) begin
      l = step(m_lfsr);
      wait_irq(n);
      check("gap", n, l[0] ? 32'd22 : 32'd12);
      exp_cnt++;
    end
    check("gap_count", irq_count, 32'(exp_cnt));
    go_idle();

    // multi mode, partial ack
    done = 1'b0;
    for (int t = 0; t < 16 && !done; t++) begin
      @(negedge clk);
      intr_intvl = 4'd1; irq_mask = 3'b111; multi_mode = 1'b1; b2b_en = 1'b0;
      intr_ack = 3'd0; intr_en = 1'b1;
      wait_irq(n);
      exp = pat1(m_prev, 3'b111);
      check("multi_pat", 32'(irq_o), 32'(exp));
      exp_cnt++;
      @(negedge clk);
      intr_en = 1'b0;
      if ($countones(exp) >= 2) begin
        low = exp & (~exp + 3'd1);
        rest = exp & ~low;
        intr_ack = low;
        @(posedge clk); #1;
        intr_ack = 3'd0;
        check("partial_hold", 32'(irq_o), 32'(rest));
        check("partial_busy", 32'(busy), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check("partial_stable", 32'(irq_o), 32'(rest));
        @(negedge clk);
        intr_ack = rest;
        @(posedge clk); #1;
        intr_ack = 3'd0;
        check("final_ack_irq", 32'(irq_o), 32'd0);
        check("final_ack_busy", 32'(busy), 32'd0);
        done = 1'b1;
      end else begin
        intr_ack = exp;
        @(posedge clk); #1;
        intr_ack = 3'd0;
        check("single_ack_irq", 32'(irq_o), 32'd0);
      end
    end
    check("multi_seen", 32'(done), 32'd1);
    check("multi_count", irq_count, 32'(exp_cnt));

    // back-to-back reloads, mask exercises the index wrap
    @(negedge clk);
    intr_intvl = 4'd1; irq_mask = 3'b011; multi_mode = 1'b0; b2b_en = 1'b1;
    intr_ack = 3'd0; intr_en = 1'b1;
    reloads = 0; drops = 0;
    for (int i = 0; i < 40; i++) begin
      if (irq_o == 3'd0) begin
        wait_irq(n);
        check("b2b_raise", 32'(irq_o), 32'(pat0(m_prev, 3'b011)));
        exp_cnt++;
      end
      @(negedge clk);
      intr_ack = irq_o;
      l = m_lfsr;
      exp = l[31] ? 3'd0 : pat0(l, 3'b011);
      @(posedge clk); #1;
      intr_ack = 3'd0;
      check("b2b_next", 32'(irq_o), 32'(exp));
      if (exp != 3'd0) begin
        reloads++;
        exp_cnt++;
      end else begin
        drops++;
        check("b2b_idle", 32'(busy), 32'd0);
      end
    end
    check("b2b_count", irq_count, 32'(exp_cnt));
    check("b2b_reloads", 32'(reloads > 0), 32'd1);
    check("b2b_drops", 32'(drops > 0), 32'd1);
    go_idle();

    // drop enable during WAIT
    @(negedge clk);
    intr_intvl = 4'd1; irq_mask = 3'b010; multi_mode = 1'b0; b2b_en = 1'b0;
    intr_ack = 3'd0; intr_en = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    intr_en = 1'b0;
    any = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (irq_o != 3'd0) any = 1;
    end
    check("wait_drop_noraise", any, 32'd0);
    check("wait_drop_busy", 32'(busy), 32'd0);
    check("wait_drop_count", irq_count, 32'(exp_cnt));

    // drop enable during ASSERT
    @(negedge clk);
    intr_en = 1'b1;
    wait_irq(n);
    exp_cnt++;
    @(negedge clk);
    intr_en = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("assert_drop_hold", 32'(irq_o), 32'b010);
    @(negedge clk);
    intr_ack = 3'b010;
    @(posedge clk); #1;
    intr_ack = 3'd0;
    check("assert_drop_irq", 32'(irq_o), 32'd0);
    check("assert_drop_busy", 32'(busy), 32'd0);
    check("assert_drop_count", irq_count, 32'(exp_cnt));

    // zero interval or empty mask never leaves IDLE
    @(negedge clk);
    intr_intvl = 4'd0; irq_mask = 3'b111; intr_en = 1'b1;
    any = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (busy) any = 1;
    end
    check("intvl0_busy", any, 32'd0);
    @(negedge clk);
    intr_intvl = 4'd3; irq_mask = 3'd0;
    any = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (busy) any = 1;
    end
    check("mask0_busy", any, 32'd0);
    go_idle();

    // asynchronous reset while a request is pending
    @(negedge clk);
    intr_intvl = 4'd1; irq_mask = 3'b010; multi_mode = 1'b0; b2b_en = 1'b0;
    intr_ack = 3'd0; intr_en = 1'b1;
    wait_irq(n);
    check("pre_rst_irq", 32'(irq_o), 32'b010);
    #2;
    rst_n = 1'b1;
    #1;
    check("async_rst_irq", 32'(irq_o), 32'd0);
    check("async_rst_count", irq_count, 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    fresh_seq();
    for (int i = 0; i < 4; i++) check("rst_replay", seq_buf[i], seq0[i]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
